// File: rtl/pio_in_pkg.sv
// Shared definitions for the Avalon-MM input PIO with edge capture.
//
// Contents:
//   ADDR_*       register word addresses on the 2-bit slave
//   EDGE_*       encodings accepted by the EDGE_TYPE parameter
//   edge_detect  per-bit edge term from current and previous filtered value
package pio_in_pkg;

   localparam logic [1:0] ADDR_DATA    = 2'd0;
   localparam logic [1:0] ADDR_RSVD    = 2'd1;
   localparam logic [1:0] ADDR_IRQMASK = 2'd2;
   localparam logic [1:0] ADDR_EDGECAP = 2'd3;

   localparam int unsigned EDGE_RISE = 0;
   localparam int unsigned EDGE_FALL = 1;
   localparam int unsigned EDGE_ANY  = 2;

   // Debounce counters are 16 bits wide, bounding DEBOUNCE_CYCLES to 65535.
   localparam int unsigned DB_CNT_W = 16;

   function automatic logic [31:0] edge_detect(input logic [31:0] cur,
                                               input logic [31:0] prev,
                                               input int unsigned kind);
      logic [31:0] term;
      case (kind)
         EDGE_RISE: term = cur & ~prev;
         EDGE_FALL: term = ~cur & prev;
         default:   term = cur ^ prev;
      endcase
      return term;
   endfunction

endpackage

// File: rtl/de1_soc_qsys_pio_in_capture_debounce.sv
// Single-bit debounce filter used by de1_soc_qsys_pio_in_capture when
// PIO_IN_DEBOUNCE_EN is defined. The output follows the input only after the
// input has differed from the output for DEBOUNCE_CYCLES consecutive clocks.
//
// Ports:
//   clk      clock, rising edge
//   reset_n  asynchronous active-low reset (output and counter clear to 0)
//   din      synchronised input bit
//   dout     filtered output bit
module pio_in_debounce
   import pio_in_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic reset_n,
   input  logic din,
   output logic dout
);

   localparam logic [DB_CNT_W-1:0] LastCnt = DB_CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [DB_CNT_W-1:0] cnt_q, cnt_d;
   logic                level_q, level_d;

   always_comb begin
      cnt_d   = '0;
      level_d = level_q;
      if (din != level_q) begin
         if (cnt_q == LastCnt) begin
            // Stable long enough: accept the new level and restart.
            level_d = din;
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q   <= '0;
         level_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         level_q <= level_d;
      end
   end

   assign dout = level_q;

endmodule

// File: rtl/de1_soc_qsys_pio_in_capture.sv
// Avalon-MM input PIO with sticky edge capture and level interrupt.
// Pins pass through a two-flop synchroniser, an optional debounce filter
// (enabled by defining PIO_IN_DEBOUNCE_EN), and an edge detector that sets
// the EDGECAP bits. irq is the OR of EDGECAP & IRQMASK.
//
// Ports:
//   clk, reset_n          clock and asynchronous active-low reset
//   address, chipselect,  2-bit Avalon-MM slave; writes when
//   write_n, writedata    chipselect & ~write_n
//   readdata              combinational read mux on address
//   in_port               asynchronous external pins
//   irq                   level interrupt, active high
//
// Register map: 0 DATA (ro), 1 reserved, 2 IRQMASK (rw), 3 EDGECAP (w1c).
module de1_soc_qsys_pio_in_capture
   import pio_in_pkg::*;
#(
   parameter int unsigned WIDTH           = 1,
   parameter int unsigned EDGE_TYPE       = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] in_port,
   output logic             irq
);

   if (WIDTH < 1 || WIDTH > 32 || EDGE_TYPE > EDGE_ANY ||
       DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535) begin : gen_bad_param
      $error("de1_soc_qsys_pio_in_capture: parameter out of range");
   end

   logic [WIDTH-1:0] sync1_q, sync2_q;
   logic [WIDTH-1:0] filt;
   logic [WIDTH-1:0] filt_dly_q;
   logic [1:0]       warm_q, warm_d;
   logic [WIDTH-1:0] irqmask_q, irqmask_d;
   logic [WIDTH-1:0] edgecap_q, edgecap_d;
   logic [WIDTH-1:0] edge_term;
   logic             wr_en;

   // Upper write-data bits beyond WIDTH carry no state.
   logic unused_writedata;
   assign unused_writedata = ^writedata;

   // ---------------------------------------------------------------------
   // Synchroniser
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= in_port;
         sync2_q <= sync1_q;
      end
   end

   // ---------------------------------------------------------------------
   // Optional debounce
   // ---------------------------------------------------------------------
`ifdef PIO_IN_DEBOUNCE_EN
   for (genvar i = 0; i < WIDTH; i++) begin : gen_db
      pio_in_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_db (
         .clk    (clk),
         .reset_n(reset_n),
         .din    (sync2_q[i]),
         .dout   (filt[i])
      );
   end
`else
   assign filt = sync2_q;
`endif

   // ---------------------------------------------------------------------
   // Edge detection with warm-up gating
   // ---------------------------------------------------------------------
   always_comb begin
      logic [31:0] cur_ext;
      logic [31:0] prev_ext;
      logic [31:0] raw;
      cur_ext              = '0;
      prev_ext             = '0;
      cur_ext[WIDTH-1:0]   = filt;
      prev_ext[WIDTH-1:0]  = filt_dly_q;
      raw                  = edge_detect(cur_ext, prev_ext, EDGE_TYPE);
      // Pins already high at reset release would otherwise look like edges
      // while the synchroniser fills.
      edge_term = (warm_q == 2'd3) ? raw[WIDTH-1:0] : '0;
      warm_d    = (warm_q == 2'd3) ? warm_q : warm_q + 2'd1;
   end

   // ---------------------------------------------------------------------
   // Register file
   // ---------------------------------------------------------------------
   assign wr_en = chipselect & ~write_n;

   always_comb begin
      irqmask_d = irqmask_q;
      edgecap_d = edgecap_q;
      if (wr_en && address == ADDR_IRQMASK) begin
         irqmask_d = writedata[WIDTH-1:0];
      end
      if (wr_en && address == ADDR_EDGECAP) begin
         edgecap_d = edgecap_q & ~writedata[WIDTH-1:0];
      end
      // A new edge wins over a simultaneous clear.
      edgecap_d = edgecap_d | edge_term;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         filt_dly_q <= '0;
         warm_q     <= '0;
         irqmask_q  <= '0;
         edgecap_q  <= '0;
      end else begin
         filt_dly_q <= filt;
         warm_q     <= warm_d;
         irqmask_q  <= irqmask_d;
         edgecap_q  <= edgecap_d;
      end
   end

   // ---------------------------------------------------------------------
   // Read mux and interrupt
   // ---------------------------------------------------------------------
   always_comb begin
      readdata = '0;
      case (address)
         ADDR_DATA:    readdata[WIDTH-1:0] = filt;
         ADDR_IRQMASK: readdata[WIDTH-1:0] = irqmask_q;
         ADDR_EDGECAP: readdata[WIDTH-1:0] = edgecap_q;
         default:      readdata = '0;
      endcase
   end

   assign irq = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_de1_soc_qsys_pio_in_capture.sv
// Directed bench for de1_soc_qsys_pio_in_capture. Two instances share the
// clock, reset, address and write strobe but have separate chipselects:
//   dut1: WIDTH=1, rising edge      dut4: WIDTH=4, any edge
// With PIO_IN_DEBOUNCE_EN defined the debounce scenarios run instead of the
// exact-latency scenarios.
module tb_de1_soc_qsys_pio_in_capture;

`ifdef PIO_IN_DEBOUNCE_EN
   localparam logic RstPin = 1'b0;
`else
   localparam logic RstPin = 1'b1;
`endif

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [1:0]  address = 2'd0;
   logic        cs1 = 1'b0;
   logic        cs4 = 1'b0;
   logic        write_n = 1'b1;
   logic [31:0] writedata = '0;
   logic [0:0]  in1 = 1'b0;
   logic [3:0]  in4 = 4'h0;
   logic [31:0] rd1, rd4;
   logic        irq1, irq4;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   de1_soc_qsys_pio_in_capture #(
      .WIDTH(1), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(16)
   ) dut1 (
      .clk       (clk),
      .reset_n   (reset_n),
      .address   (address),
      .chipselect(cs1),
      .write_n   (write_n),
      .writedata (writedata),
      .readdata  (rd1),
      .in_port   (in1),
      .irq       (irq1)
   );

   de1_soc_qsys_pio_in_capture #(
      .WIDTH(4), .EDGE_TYPE(2), .DEBOUNCE_CYCLES(16)
   ) dut4 (
      .clk       (clk),
      .reset_n   (reset_n),
      .address   (address),
      .chipselect(cs4),
      .write_n   (write_n),
      .writedata (writedata),
      .readdata  (rd4),
      .in_port   (in4),
      .irq       (irq4)
   );

   task automatic wr1(input logic [1:0] a, input logic [31:0] d);
      @(posedge clk); #1;
      address = a; writedata = d; cs1 = 1'b1; write_n = 1'b0;
      @(posedge clk); #1;
      cs1 = 1'b0; write_n = 1'b1;
   endtask

   task automatic wr4(input logic [1:0] a, input logic [31:0] d);
      @(posedge clk); #1;
      address = a; writedata = d; cs4 = 1'b1; write_n = 1'b0;
      @(posedge clk); #1;
      cs4 = 1'b0; write_n = 1'b1;
   endtask

   task automatic sel(input logic [1:0] a);
      address = a;
      #1;
   endtask

   task automatic test_reset;
      in1 = RstPin;
      in4 = {4{RstPin}};
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      sel(2'd0);
      n_vec++; if (rd1 !== 32'h0) begin n_err++;
         $display("FAIL reset_data_in_reset: got %h want %h", rd1, 32'h0); end
      n_vec++; if (irq1 !== 1'b0) begin n_err++;
         $display("FAIL reset_irq_in_reset: got %b want 0", irq1); end
      reset_n = 1'b1;
      repeat (10) @(posedge clk);
      @(negedge clk);
      sel(2'd3);
      n_vec++; if (rd1 !== 32'h0) begin n_err++;
         $display("FAIL reset_edgecap1: got %h want %h", rd1, 32'h0); end
      n_vec++; if (rd4 !== 32'h0) begin n_err++;
         $display("FAIL reset_edgecap4: got %h want %h", rd4, 32'h0); end
      n_vec++; if (irq1 !== 1'b0) begin n_err++;
         $display("FAIL reset_irq1: got %b want 0", irq1); end
      sel(2'd0);
      n_vec++; if (rd1 !== {31'h0, RstPin}) begin n_err++;
         $display("FAIL reset_data1: got %h want %h", rd1, {31'h0, RstPin}); end
      n_vec++; if (rd4 !== {28'h0, {4{RstPin}}}) begin n_err++;
         $display("FAIL reset_data4: got %h want %h", rd4, {28'h0, {4{RstPin}}}); end
      sel(2'd1);
      n_vec++; if (rd4 !== 32'h0) begin n_err++;
         $display("FAIL reset_rsvd4: got %h want %h", rd4, 32'h0); end
   endtask

   task automatic test_rise_irq;
      wr1(2'd2, 32'h1);
      in1 = 1'b0;
      repeat (6) @(posedge clk);
      @(negedge clk);
      sel(2'd3);
      n_vec++; if (rd1 !== 32'h0) begin n_err++;
         $display("FAIL fall_ignored: got %h want %h", rd1, 32'h0); end
      n_vec++; if (irq1 !== 1'b0) begin n_err++;
         $display("FAIL fall_irq: got %b want 0", irq1); end
      @(posedge clk); #1;
      in1 = 1'b1;
      @(negedge clk);   // before E1
      @(negedge clk);   // after E1
      sel(2'd0);
      n_vec++; if (rd1 !== 32'h0) begin n_err++;
         $display("FAIL rise_data_e1: got %h want %h", rd1, 32'h0); end
      @(negedge clk);   // after E2
      sel(2'd0);
      n_vec++; if (rd1 !== 32'h1) begin n_err++;
         $display("FAIL rise_data_e2: got %h want %h", rd1, 32'h1); end
      sel(2'd3);
      n_vec++; if (rd1 !== 32'h0) begin n_err++;
         $display("FAIL rise_cap_e2: got %h want %h", rd1, 32'h0); end
      n_vec++; if (irq1 !== 1'b0) begin n_err++;
         $display("FAIL rise_irq_e2: got %b want 0", irq1); end
      @(negedge clk);   // after E3
      sel(2'd3);
      n_vec++; if (rd1 !== 32'h1) begin n_err++;
         $display("FAIL rise_cap_e3: got %h want %h", rd1, 32'h1); end
      n_vec++; if (irq1 !== 1'b1) begin n_err++;
         $display("FAIL rise_irq_e3: got %b want 1", irq1); end
      sel(2'd2);
      n_vec++; if (rd1 !== 32'h1) begin n_err++;
         $display("FAIL rise_mask_rb: got %h want %h", rd1, 32'h1); end
      wr1(2'd3, 32'h1);
      n_vec++; if (irq1 !== 1'b0) begin n_err++;
         $display("FAIL w1c_irq: got %b want 0", irq1); end
      sel(2'd3);
      n_vec++; if (rd1 !== 32'h0) begin n_err++;
         $display("FAIL w1c_cap: got %h want %h", rd1, 32'h0); end
   endtask

   task automatic test_w1c_mask;
      @(posedge clk); #1;
      in4 = 4'hB;       // bit 2 falls
      repeat (6) @(posedge clk);
      @(negedge clk);
      sel(2'd3);
      n_vec++; if (rd4 !== 32'h4) begin n_err++;
         $display("FAIL any_cap_bit2: got %h want %h", rd4, 32'h4); end
      n_vec++; if (irq4 !== 1'b0) begin n_err++;
         $display("FAIL any_irq_masked: got %b want 0", irq4); end
      wr4(2'd3, 32'h0);
      sel(2'd3);
      n_vec++; if (rd4 !== 32'h4) begin n_err++;
         $display("FAIL w1c_zero: got %h want %h", rd4, 32'h4); end
      wr4(2'd2, 32'h4);
      n_vec++; if (irq4 !== 1'b1) begin n_err++;
         $display("FAIL mask_irq: got %b want 1", irq4); end
      wr4(2'd3, 32'h4);
      sel(2'd3);
      n_vec++; if (rd4 !== 32'h0) begin n_err++;
         $display("FAIL w1c_bit2: got %h want %h", rd4, 32'h0); end
      n_vec++; if (irq4 !== 1'b0) begin n_err++;
         $display("FAIL w1c_bit2_irq: got %b want 0", irq4); end
      sel(2'd0);
      n_vec++; if (rd4 !== 32'hB) begin n_err++;
         $display("FAIL any_data: got %h want %h", rd4, 32'hB); end
   endtask

   task automatic test_set_wins;
      @(posedge clk); #1;
      in4 = 4'hA;       // bit 0 falls
      repeat (6) @(posedge clk);
      @(negedge clk);
      sel(2'd3);
      n_vec++; if (rd4 !== 32'h1) begin n_err++;
         $display("FAIL setwins_pre: got %h want %h", rd4, 32'h1); end
      @(posedge clk); #1;
      in4 = 4'hB;       // bit 0 rises; captured at E3
      @(posedge clk); #1;   // E1
      @(posedge clk); #1;   // E2
      address = 2'd3; writedata = 32'h1; cs4 = 1'b1; write_n = 1'b0;
      @(posedge clk); #1;   // E3: edge and clear together
      cs4 = 1'b0; write_n = 1'b1;
      sel(2'd3);
      n_vec++; if (rd4 !== 32'h1) begin n_err++;
         $display("FAIL setwins: got %h want %h", rd4, 32'h1); end
      repeat (3) @(posedge clk);
      @(negedge clk);
      sel(2'd3);
      n_vec++; if (rd4 !== 32'h1) begin n_err++;
         $display("FAIL setwins_hold: got %h want %h", rd4, 32'h1); end
      wr4(2'd3, 32'h1);
      sel(2'd3);
      n_vec++; if (rd4 !== 32'h0) begin n_err++;
         $display("FAIL setwins_clear: got %h want %h", rd4, 32'h0); end
   endtask

   task automatic test_debounce;
      wr1(2'd2, 32'h1);
      @(posedge clk); #1;
      in1 = 1'b1;
      repeat (10) @(posedge clk);
      #1 in1 = 1'b0;
      repeat (30) @(posedge clk);
      @(negedge clk);
      sel(2'd0);
      n_vec++; if (rd1 !== 32'h0) begin n_err++;
         $display("FAIL db_short_data: got %h want %h", rd1, 32'h0); end
      sel(2'd3);
      n_vec++; if (rd1 !== 32'h0) begin n_err++;
         $display("FAIL db_short_cap: got %h want %h", rd1, 32'h0); end
      @(posedge clk); #1;
      in1 = 1'b1;
      repeat (18) @(negedge clk);   // after E17: sync2 high since E2
      sel(2'd0);
      n_vec++; if (rd1 !== 32'h0) begin n_err++;
         $display("FAIL db_long_early: got %h want %h", rd1, 32'h0); end
      @(negedge clk);               // after E18
      sel(2'd0);
      n_vec++; if (rd1 !== 32'h1) begin n_err++;
         $display("FAIL db_long_data: got %h want %h", rd1, 32'h1); end
      sel(2'd3);
      n_vec++; if (rd1 !== 32'h0) begin n_err++;
         $display("FAIL db_long_cap_early: got %h want %h", rd1, 32'h0); end
      @(negedge clk);               // after E19
      sel(2'd3);
      n_vec++; if (rd1 !== 32'h1) begin n_err++;
         $display("FAIL db_long_cap: got %h want %h", rd1, 32'h1); end
      n_vec++; if (irq1 !== 1'b1) begin n_err++;
         $display("FAIL db_long_irq: got %b want 1", irq1); end
      in1 = 1'b0;
      wr1(2'd3, 32'h1);
   endtask

   task automatic test_async_reset;
      wr1(2'd2, 32'h1);
      in1 = 1'b0;
      repeat (40) @(posedge clk);
      #1 in1 = 1'b1;
      repeat (40) @(posedge clk);
      #2;
      sel(2'd3);
      n_vec++; if (rd1 !== 32'h1) begin n_err++;
         $display("FAIL arst_pre_cap: got %h want %h", rd1, 32'h1); end
      n_vec++; if (irq1 !== 1'b1) begin n_err++;
         $display("FAIL arst_pre_irq: got %b want 1", irq1); end
      reset_n = 1'b0;
      #1;
      n_vec++; if (irq1 !== 1'b0) begin n_err++;
         $display("FAIL arst_irq: got %b want 0", irq1); end
      n_vec++; if (rd1 !== 32'h0) begin n_err++;
         $display("FAIL arst_cap: got %h want %h", rd1, 32'h0); end
      sel(2'd2);
      n_vec++; if (rd1 !== 32'h0) begin n_err++;
         $display("FAIL arst_mask: got %h want %h", rd1, 32'h0); end
   endtask

   initial begin
      test_reset();
`ifdef PIO_IN_DEBOUNCE_EN
      test_debounce();
`else
      test_rise_irq();
      test_w1c_mask();
      test_set_wins();
`endif
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/de1_soc_qsys_pio_in_capture.md
# de1_soc_qsys_pio_in_capture

Avalon-MM input port with edge capture and a level interrupt, `WIDTH` bits wide. It is the read-side counterpart of the QSYS output PIOs. Typical uses are sampling I2C SDA/SCL readback and pushbuttons on the DE1-SoC. External pins are synchronised, optionally debounced, and edge-detected into sticky capture bits, which the HPS/Nios reads and clears over the same 2-bit-address slave used by the output PIOs.

## Interface
Parameters:
- `WIDTH`, 1: number of input bits (1..32).
- `EDGE_TYPE`, 2: edge that sets a capture bit. 0 = rising, 1 = falling, 2 = any.
- `DEBOUNCE_CYCLES`, 16: filter length in clocks (2..65535). Used only with `PIO_IN_DEBOUNCE_EN`.

Ports:
- `clk` input 1: single clock, all logic rising-edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `address` input 2: register select.
- `chipselect` input 1: slave select.
- `write_n` input 1: active-low write strobe.
- `writedata` input 32: write data.
- `readdata` output 32: read data, combinational from `address`, zero-wait-state.
- `in_port` input `WIDTH`: asynchronous external pins.
- `irq` output 1: level interrupt, active-high.

## Operation
Register map (bits above `WIDTH` read 0):
- Address 0, DATA: read returns the filtered input value `filt`. Writes are ignored.
- Address 1, reserved: reads 0, writes ignored.
- Address 2, IRQMASK: read/write, reset 0.
- Address 3, EDGECAP: read returns the capture bits. Writing 1 to a bit clears it; writing 0 leaves it unchanged. Reset 0.

Datapath:
- Two-flop synchroniser: `in_port` → `sync1` → `sync2`.
- `filt` = `sync2` (no debounce); with debounce, see Configuration.
- `filt_d` is `filt` delayed by one clock.
- Edge term per bit:
  - rising: `filt & ~filt_d`
  - falling: `~filt & filt_d`
  - any: `filt ^ filt_d`
- Warm-up counter (2 bits, reset 0) counts up to 3 and then saturates. Edge terms are forced to 0 until it reaches 3. This suppresses spurious edges when pins are high at reset release.
- Capture bit update: set if edge term is 1, else clear if written 1, else hold. If set and clear happen in the same cycle, set wins.
- `irq` = OR-reduce(EDGECAP & IRQMASK), combinational from registers.

Reset values: all registers are 0. Therefore `readdata` = 0 and `irq` = 0 during reset. An assertion of `reset_n` mid-operation clears every register immediately, including pending captures and debounce counters.

## Timing
Without debounce, for an `in_port` change sampled at clock edge E1:
- DATA reflects the new value after E2.
- EDGECAP sets at E3.
- `irq` rises after E3 if the bit is masked in.

Other timing:
- Register writes take effect at the edge where `chipselect & ~write_n` is sampled.
- A read in the same cycle as a write returns the pre-write value.
- After a W1C clear at edge Ek, `irq` deasserts after Ek unless a new edge also lands at Ek.
- Pulses shorter than one clock may be missed. This is permitted.

## Configuration
`PIO_IN_DEBOUNCE_EN`:
- Defined:
  - Per-bit 16-bit counter, reset 0.
  - While `sync2 != filt`, the counter increments. When `sync2 == filt`, the counter resets to 0.
  - When the counter reaches `DEBOUNCE_CYCLES-1` while still differing, `filt` takes `sync2` at the next edge and the counter resets.
  - Result: a change must be stable for `DEBOUNCE_CYCLES` clocks. Added latency is exactly `DEBOUNCE_CYCLES` clocks.
  - Glitches shorter than that produce no DATA change and no capture.
- Undefined: no counters are built; `filt` = `sync2`.

## Structure
- Shared package `pio_in_pkg`:
  - Register address constants: `ADDR_DATA`=0, `ADDR_IRQMASK`=2, `ADDR_EDGECAP`=3.
  - `EDGE_TYPE` encodings: `EDGE_RISE`, `EDGE_FALL`, `EDGE_ANY`.
- One sub-module, `pio_in_debounce`: a single-bit debounce filter, instantiated `WIDTH` times under the macro.
- Synchroniser, edge logic and register file stay in the top level.

## Test plan
- Reset with `in_port`=1 (WIDTH=1, EDGE_TYPE=0), release, wait 10 clocks → EDGECAP reads 0, `irq`=0, DATA reads 1.
- Write IRQMASK=1; drive `in_port` 0→1 sampled at E1 → DATA=1 after E2, EDGECAP=1 at E3, `irq`=1 after E3. Write EDGECAP=1 → `irq`=0 the next cycle.
- EDGE_TYPE=2, WIDTH=4: toggle bit 2 only → EDGECAP=0x4. Write 0x0 to EDGECAP → still 0x4. Write 0x4 → 0x0.
- Edge on bit 0 and W1C of bit 0 land on the same edge → EDGECAP bit 0 remains 1 (set wins).
- With `PIO_IN_DEBOUNCE_EN`, `DEBOUNCE_CYCLES`=16:
  - A 10-clock high pulse → DATA stays 0, no capture.
  - A 20-clock high pulse → DATA=1 exactly 16 clocks after `sync2` rises, capture set one clock later.
- Assert `reset_n` low while EDGECAP=0x1 and IRQMASK=0x1 → `irq` and `readdata` go to 0 asynchronously, without waiting for a clock edge.
